// File: rtl/vga_pkg.sv
// Shared timing defaults, scan-control bundle and elaboration helpers for the VGA scan generator.
// Defaults describe the 640x480 raster; instances may override any of them.
package vga_pkg;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 32;
   localparam int DEF_H_SYNC   = 48;
   localparam int DEF_H_BP     = 112;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 1;
   localparam int DEF_V_SYNC   = 3;
   localparam int DEF_V_BP     = 25;
   localparam int DEF_COLOR_W  = 1;
   localparam int DEF_PIX_LAT  = 1;
   localparam int DEF_CW       = 10;

   // Active-high internal view of sync/active; pin polarity is applied at the output register.
   typedef struct packed {
      logic hs;
      logic vs;
      logic act;
   } scan_ctl_t;

   localparam scan_ctl_t CTL_IDLE = '{hs: 1'b0, vs: 1'b0, act: 1'b0};

   function automatic int line_total(input int fp, input int sync, input int bp, input int active);
      return fp + sync + bp + active;
   endfunction

   function automatic int h_total(input int fp, input int sync, input int bp, input int active);
      return line_total(fp, sync, bp, active);
   endfunction

   function automatic int v_total(input int fp, input int sync, input int bp, input int active);
      return line_total(fp, sync, bp, active);
   endfunction

   // A counter of cw bits must be able to reach total-1.
   function automatic bit width_covers(input int total, input int cw);
      return (cw >= 1) && ((cw >= 31) || (total <= (1 << cw)));
   endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Enable-gated shift register carrying scan control bits; DEPTH=0 degenerates to a wire.
module vga_delay_line #(
   parameter int               WIDTH   = 1,
   parameter int               DEPTH   = 1,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             en_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   if (DEPTH == 0) begin : g_bypass
      logic unused_ctl;
      assign unused_ctl = &{1'b0, clk_i, rst_ni, en_i};
      assign q_o        = d_i;
   end else begin : g_shift
      logic [WIDTH-1:0] stage_q [DEPTH];

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
               stage_q[i] <= RST_VAL;
            end
         end else if (en_i) begin
            stage_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
               stage_q[i] <= stage_q[i-1];
            end
         end
      end

      assign q_o = stage_q[DEPTH-1];
   end

endmodule

// File: rtl/vga_scan_gen.sv
// VGA scan generator: issues pixel coordinates ahead of the beam and re-aligns the renderer's
// colour with delayed syncs so every pin changes on the same enabled cycle.
module vga_scan_gen
   import vga_pkg::*;
#(
   parameter int   H_ACTIVE = DEF_H_ACTIVE,
   parameter int   H_FP     = DEF_H_FP,
   parameter int   H_SYNC   = DEF_H_SYNC,
   parameter int   H_BP     = DEF_H_BP,
   parameter int   V_ACTIVE = DEF_V_ACTIVE,
   parameter int   V_FP     = DEF_V_FP,
   parameter int   V_SYNC   = DEF_V_SYNC,
   parameter int   V_BP     = DEF_V_BP,
   parameter logic HS_POL   = 1'b0,
   parameter logic VS_POL   = 1'b0,
   parameter int   COLOR_W  = DEF_COLOR_W,
   parameter int   PIX_LAT  = DEF_PIX_LAT,
   parameter int   CW       = DEF_CW
) (
   input  logic                 dclk,
   input  logic                 clr,
   input  logic                 en,
   input  logic [3*COLOR_W-1:0] rgb_in,
   output logic [CW-1:0]        x,
   output logic [CW-1:0]        y,
   output logic                 req_valid,
   output logic                 hsync,
   output logic                 vsync,
   output logic [COLOR_W-1:0]   red,
   output logic [COLOR_W-1:0]   green,
   output logic [COLOR_W-1:0]   blue,
   output logic                 line_start,
   output logic                 frame_start,
   output logic [7:0]           frame_cnt
);

   localparam int H_TOTAL = h_total(H_FP, H_SYNC, H_BP, H_ACTIVE);
   localparam int V_TOTAL = v_total(V_FP, V_SYNC, V_BP, V_ACTIVE);

   localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] H_SYNC_BEG = CW'(H_FP);
   localparam logic [CW-1:0] H_SYNC_END = CW'(H_FP + H_SYNC);
   localparam logic [CW-1:0] H_BLANK    = CW'(H_FP + H_SYNC + H_BP);
   localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0] V_SYNC_BEG = CW'(V_FP);
   localparam logic [CW-1:0] V_SYNC_END = CW'(V_FP + V_SYNC);
   localparam logic [CW-1:0] V_BLANK    = CW'(V_FP + V_SYNC + V_BP);

   if (!width_covers(H_TOTAL, CW) || !width_covers(V_TOTAL, CW)) begin : g_cw_check
      $error("vga_scan_gen: CW=%0d cannot hold H_TOTAL-1=%0d / V_TOTAL-1=%0d",
             CW, H_TOTAL - 1, V_TOTAL - 1);
   end
   if (COLOR_W < 1 || COLOR_W > 8 || PIX_LAT < 0 || PIX_LAT > 15) begin : g_param_check
      $error("vga_scan_gen: COLOR_W=%0d or PIX_LAT=%0d out of range", COLOR_W, PIX_LAT);
   end

   logic [CW-1:0]        hc_q, hc_d, vc_q, vc_d;
   logic [CW-1:0]        x_q, x_d, y_q, y_d;
   logic                 req_valid_q, req_valid_d;
   logic [7:0]           frame_cnt_q, frame_cnt_d;
   logic [3*COLOR_W-1:0] rgb_q;
   logic                 hsync_q, vsync_q;
   scan_ctl_t            ctl0, ctl_dly;

   // Coordinates are computed from the next counter value so they line up with the stage-0 flags.
   always_comb begin
      hc_d        = hc_q;
      vc_d        = vc_q;
      frame_cnt_d = frame_cnt_q;
      if (en) begin
         if (hc_q == H_LAST) begin
            hc_d = '0;
            if (vc_q == V_LAST) begin
               vc_d        = '0;
               frame_cnt_d = frame_cnt_q + 8'd1;
            end else begin
               vc_d = vc_q + 1'b1;
            end
         end else begin
            hc_d = hc_q + 1'b1;
         end
      end
      req_valid_d = (hc_d >= H_BLANK) && (vc_d >= V_BLANK);
      x_d         = req_valid_d ? hc_d - H_BLANK : '0;
      y_d         = req_valid_d ? vc_d - V_BLANK : '0;
   end

   always_ff @(posedge dclk or negedge clr) begin
      if (!clr) begin
         hc_q        <= '0;
         vc_q        <= '0;
         frame_cnt_q <= '0;
         x_q         <= '0;
         y_q         <= '0;
         req_valid_q <= 1'b0;
      end else if (en) begin
         hc_q        <= hc_d;
         vc_q        <= vc_d;
         frame_cnt_q <= frame_cnt_d;
         x_q         <= x_d;
         y_q         <= y_d;
         req_valid_q <= req_valid_d;
      end
   end

   always_comb begin
      ctl0     = CTL_IDLE;
      ctl0.hs  = (hc_q >= H_SYNC_BEG) && (hc_q < H_SYNC_END);
      ctl0.vs  = (vc_q >= V_SYNC_BEG) && (vc_q < V_SYNC_END);
      ctl0.act = (hc_q >= H_BLANK) && (vc_q >= V_BLANK);
   end

   vga_delay_line #(
      .WIDTH  ($bits(scan_ctl_t)),
      .DEPTH  (PIX_LAT),
      .RST_VAL(CTL_IDLE)
   ) u_ctl_delay (
      .clk_i (dclk),
      .rst_ni(clr),
      .en_i  (en),
      .d_i   (ctl0),
      .q_o   (ctl_dly)
   );

   // rgb_in is only looked at while the delayed active flag is set, so junk in blanking never leaks.
   always_ff @(posedge dclk or negedge clr) begin
      if (!clr) begin
         rgb_q   <= '0;
         hsync_q <= ~HS_POL;
         vsync_q <= ~VS_POL;
      end else if (en) begin
         rgb_q   <= ctl_dly.act ? rgb_in : '0;
         hsync_q <= ctl_dly.hs ? HS_POL : ~HS_POL;
         vsync_q <= ctl_dly.vs ? VS_POL : ~VS_POL;
      end
   end

   assign x           = x_q;
   assign y           = y_q;
   assign req_valid   = req_valid_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign red         = rgb_q[3*COLOR_W-1 -: COLOR_W];
   assign green       = rgb_q[2*COLOR_W-1 -: COLOR_W];
   assign blue        = rgb_q[COLOR_W-1:0];
   assign frame_cnt   = frame_cnt_q;
   assign line_start  = clr & en & (hc_q == '0);
   assign frame_start = line_start & (vc_q == '0);

endmodule

// File: tb/tb_vga_scan_gen.sv
// Directed bench for vga_scan_gen on a reduced 16x8 raster with a 2-cycle renderer model;
// a second instance with active-high syncs runs in lockstep.
module tb_vga_scan_gen;

   localparam int              CW       = 10;
   localparam int              COLOR_W  = 2;
   localparam int              RGB_W    = 3 * COLOR_W;
   localparam logic [RGB_W-1:0] JUNK_RGB = 6'h2A;

   logic               dclk  = 1'b0;
   logic               clr   = 1'b0;
   logic               en    = 1'b0;
   logic [RGB_W-1:0]   rgbIn = '0;

   logic [CW-1:0]      x, y, xP, yP;
   logic               reqValid, hsync, vsync, lineStart, frameStart;
   logic               reqValidP, hsyncP, vsyncP, lineStartP, frameStartP;
   logic [COLOR_W-1:0] red, green, blue, redP, greenP, blueP;
   logic [7:0]         frameCnt, frameCntP;

   int testsRun    = 0;
   int testsFailed = 0;

   int            refHc, refVc, refFc;
   int            pipeHc [3];
   int            pipeVc [3];
   logic          pipeValid [3];
   logic [CW-1:0] rendX1, rendY1, rendX2, rendY2;
   logic          rendV1, rendV2;

   always #5 dclk = ~dclk;

   vga_scan_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .HS_POL(1'b0), .VS_POL(1'b0), .COLOR_W(COLOR_W), .PIX_LAT(2), .CW(CW)
   ) dut (
      .dclk(dclk), .clr(clr), .en(en), .rgb_in(rgbIn),
      .x(x), .y(y), .req_valid(reqValid), .hsync(hsync), .vsync(vsync),
      .red(red), .green(green), .blue(blue),
      .line_start(lineStart), .frame_start(frameStart), .frame_cnt(frameCnt)
   );

   vga_scan_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .HS_POL(1'b1), .VS_POL(1'b1), .COLOR_W(COLOR_W), .PIX_LAT(2), .CW(CW)
   ) dutP (
      .dclk(dclk), .clr(clr), .en(en), .rgb_in(rgbIn),
      .x(xP), .y(yP), .req_valid(reqValidP), .hsync(hsyncP), .vsync(vsyncP),
      .red(redP), .green(greenP), .blue(blueP),
      .line_start(lineStartP), .frame_start(frameStartP), .frame_cnt(frameCntP)
   );

   // Renderer picture: never zero for x in 0..7, y in 0..3.
   function automatic logic [RGB_W-1:0] colorOf(input int px, input int py);
      return RGB_W'((px * 7 + py * 13 + 1) & 63);
   endfunction

   task automatic checkVal(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testsRun++;
      assert (observed === expected)
      else begin
         testsFailed++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic resetModel();
      refHc = 0;
      refVc = 0;
      refFc = 0;
      for (int i = 0; i < 3; i++) begin
         pipeHc[i]    = 0;
         pipeVc[i]    = 0;
         pipeValid[i] = 1'b0;
      end
      rendX1 = '0; rendY1 = '0; rendV1 = 1'b0;
      rendX2 = '0; rendY2 = '0; rendV2 = 1'b0;
      rgbIn  = JUNK_RGB;
   endtask

   task automatic checkResetState(input string tag);
      checkVal({tag, ".x"}, 32'(x), 32'(0));
      checkVal({tag, ".y"}, 32'(y), 32'(0));
      checkVal({tag, ".req"}, 32'(reqValid), 32'(0));
      checkVal({tag, ".hsync"}, 32'(hsync), 32'(1));
      checkVal({tag, ".vsync"}, 32'(vsync), 32'(1));
      checkVal({tag, ".hsyncP"}, 32'(hsyncP), 32'(0));
      checkVal({tag, ".vsyncP"}, 32'(vsyncP), 32'(0));
      checkVal({tag, ".rgb"}, 32'({red, green, blue}), 32'(0));
      checkVal({tag, ".fcnt"}, 32'(frameCnt), 32'(0));
      checkVal({tag, ".lstart"}, 32'(lineStart), 32'(0));
      checkVal({tag, ".fstart"}, 32'(frameStart), 32'(0));
   endtask

   task automatic applyReset();
      clr = 1'b0;
      resetModel();
      repeat (2) @(posedge dclk);
      #1;
      checkResetState("rst");
      #1;
      clr = 1'b1;
      #1;
   endtask

   task automatic applyStimulus(input logic enVal);
      en = enVal;
      #1;
   endtask

   // One clock: renderer and reference advance only on enabled edges.
   task automatic tick();
      logic [CW-1:0] sx, sy;
      logic          sv, enWas;
      sx    = x;
      sy    = y;
      sv    = reqValid;
      enWas = en;
      @(posedge dclk);
      #1;
      if (enWas) begin
         rendX2 = rendX1; rendY2 = rendY1; rendV2 = rendV1;
         rendX1 = sx;     rendY1 = sy;     rendV1 = sv;
         for (int i = 2; i > 0; i--) begin
            pipeHc[i]    = pipeHc[i-1];
            pipeVc[i]    = pipeVc[i-1];
            pipeValid[i] = pipeValid[i-1];
         end
         pipeHc[0]    = refHc;
         pipeVc[0]    = refVc;
         pipeValid[0] = 1'b1;
         if (refHc == 15) begin
            refHc = 0;
            if (refVc == 7) begin
               refVc = 0;
               refFc = (refFc + 1) % 256;
            end else begin
               refVc++;
            end
         end else begin
            refHc++;
         end
      end
      rgbIn = rendV2 ? colorOf(int'(rendX2), int'(rendY2)) : JUNK_RGB;
   endtask

   task automatic checkOutput(input string tag);
      logic            expHs, expVs, expAct, curAct;
      logic [RGB_W-1:0] expRgb;
      int              expX, expY;
      expHs  = pipeValid[2] && pipeHc[2] >= 2 && pipeHc[2] < 5;
      expVs  = pipeValid[2] && pipeVc[2] >= 1 && pipeVc[2] < 3;
      expAct = pipeValid[2] && pipeHc[2] >= 8 && pipeVc[2] >= 4;
      expRgb = expAct ? colorOf(pipeHc[2] - 8, pipeVc[2] - 4) : '0;
      curAct = refHc >= 8 && refVc >= 4;
      expX   = curAct ? refHc - 8 : 0;
      expY   = curAct ? refVc - 4 : 0;
      checkVal({tag, ".x"}, 32'(x), expX);
      checkVal({tag, ".y"}, 32'(y), expY);
      checkVal({tag, ".req"}, 32'(reqValid), 32'(curAct));
      checkVal({tag, ".hsync"}, 32'(hsync), 32'(!expHs));
      checkVal({tag, ".vsync"}, 32'(vsync), 32'(!expVs));
      checkVal({tag, ".rgb"}, 32'({red, green, blue}), 32'(expRgb));
      checkVal({tag, ".lstart"}, 32'(lineStart), 32'(en && refHc == 0));
      checkVal({tag, ".fstart"}, 32'(frameStart), 32'(en && refHc == 0 && refVc == 0));
      checkVal({tag, ".fcnt"}, 32'(frameCnt), refFc);
      checkVal({tag, ".xP"}, 32'(xP), expX);
      checkVal({tag, ".yP"}, 32'(yP), expY);
      checkVal({tag, ".reqP"}, 32'(reqValidP), 32'(curAct));
      checkVal({tag, ".hsyncP"}, 32'(hsyncP), 32'(expHs));
      checkVal({tag, ".vsyncP"}, 32'(vsyncP), 32'(expVs));
      checkVal({tag, ".rgbP"}, 32'({redP, greenP, blueP}), 32'(expRgb));
      checkVal({tag, ".lstartP"}, 32'(lineStartP), 32'(en && refHc == 0));
      checkVal({tag, ".fstartP"}, 32'(frameStartP), 32'(en && refHc == 0 && refVc == 0));
      checkVal({tag, ".fcntP"}, 32'(frameCntP), refFc);
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int hsFirstLow, hsLowLine0, frameStarts, lineStarts, reqCount, pinCount, idleStarts, found;

      // Reset with en held high, then two free-running frames.
      en = 1'b1;
      applyReset();
      hsFirstLow = -1; hsLowLine0 = 0; frameStarts = 0; lineStarts = 0; reqCount = 0; pinCount = 0;
      for (int i = 0; i < 256; i++) begin
         applyStimulus(1'b1);
         checkOutput("t1");
         if (frameStart) frameStarts++;
         if (lineStart) lineStarts++;
         if (!hsync && hsFirstLow < 0) hsFirstLow = i;
         if (!hsync && i < 16) hsLowLine0++;
         if (reqValid && i < 128) reqCount++;
         if ({red, green, blue} != '0 && i >= 3 && i <= 130) pinCount++;
         tick();
      end
      checkVal("t1.firstHsLow", hsFirstLow, 5);
      checkVal("t1.hsLowWidth", hsLowLine0, 3);
      checkVal("t1.frameStarts", frameStarts, 2);
      checkVal("t1.lineStarts", lineStarts, 16);
      checkVal("t2.reqPerFrame", reqCount, 32);
      checkVal("t2.pinsPerFrame", pinCount, 32);

      // Clock enable alternating: every value held for two cycles, no pulses while idle.
      lineStarts = 0; idleStarts = 0;
      for (int i = 0; i < 512; i++) begin
         applyStimulus(i % 2 == 0);
         checkOutput("t3");
         if (lineStart && en) lineStarts++;
         if ((lineStart || frameStart) && !en) idleStarts++;
         tick();
      end
      checkVal("t3.lineStarts", lineStarts, 16);
      checkVal("t3.idlePulses", idleStarts, 0);
      checkVal("t3.frameCnt", 32'(frameCnt), 4);

      // Asynchronous reset pulse in the middle of an active line.
      found = 0;
      for (int i = 0; i < 256 && found == 0; i++) begin
         applyStimulus(1'b1);
         if (refHc == 11 && refVc == 6) found = 1;
         else tick();
      end
      checkVal("t5.reachPoint", found, 1);
      checkVal("t5.preRgbNonZero", 32'({red, green, blue} != '0), 32'(1));
      clr = 1'b0;
      #1;
      checkResetState("t5.inReset");
      resetModel();
      #1;
      clr = 1'b1;
      #1;
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1);
         checkOutput("t5");
         if (i == 0) checkVal("t5.firstFrameStart", 32'(frameStart), 32'(1));
         if (i < 3) begin
            checkVal("t5.flushRgb", 32'({red, green, blue}), 32'(0));
            checkVal("t5.flushHsync", 32'(hsync), 32'(1));
         end
         tick();
      end

      // Frame counter over a full 256-frame wrap.
      applyReset();
      for (int i = 0; i <= 256 * 128; i++) begin
         applyStimulus(1'b1);
         if (refHc == 0 && refVc == 0) checkVal("t6.fcnt", 32'(frameCnt), refFc);
         if (i == 255 * 128) checkVal("t6.at255", 32'(frameCnt), 255);
         if (i == 256 * 128 - 1) checkVal("t6.preWrap", 32'(frameCnt), 255);
         if (i == 256 * 128) checkVal("t6.wrap", 32'(frameCnt), 0);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
